// File: rtl/booth_seq_controller_pkg.sv
// rtl/booth_seq_controller_pkg.sv - shared types and helpers for the Booth sequencer
// Purpose: state encoding constants, ALU opcode enum and the Booth pair decoder
//          used by booth_seq_controller and the surrounding datapath.
package booth_seq_controller_pkg;

  // State encoding kept as plain constants so legacy netlists and probes that
  // decode the raw 2-bit state keep working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_CALC = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_e;

  // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out
  // last: a 1->0 boundary (10) subtracts, a 0->1 boundary (01) adds.
  function automatic alu_op_e booth_op_f(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b10:   booth_op_f = ALU_SUB;
      2'b01:   booth_op_f = ALU_ADD;
      default: booth_op_f = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_controller.sv
// rtl/booth_seq_controller.sv - sequencer FSM for the radix-2 Booth sequential multiplier
// Purpose: steps the datapath through operand load, WIDTH_M shift/add iterations,
//          result hold and register clear, with a CALC watchdog and sticky error flag.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   src_valid / src_ready      operand handshake (ready only in IDLE)
//   dst_valid / dst_ready      product handshake (valid only in DONE)
//   count_done, Q0, Q_1        datapath status: iteration count reached, Booth pair
//   start                      one-cycle pulse while loading operands
//   en_mltd, en_multr, en_ac   register enables: multiplicand, multiplier+Q_1, accumulator
//   en_count                   iteration counter enable
//   alu_op                     ALU_PASS / ALU_ADD / ALU_SUB
//   selQ, selA, selQ_1         0 = load operand/zero, 1 = shifted feedback
//   en_out                     1 blanks the product bus, 0 only while DONE
//   clear                      one-cycle synchronous clear of datapath regs/counter
//   busy, err                  state != IDLE, sticky watchdog abort flag
module booth_seq_controller
  import booth_seq_controller_pkg::*;
#(
  parameter int WIDTH_M = 16,
  parameter int WIDTH_P = 2 * WIDTH_M,
  parameter int TIMEOUT = WIDTH_M + 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       dst_valid,
  input  logic       dst_ready,
  input  logic       count_done,
  input  logic       Q0,
  input  logic       Q_1,
  output logic       start,
  output logic       en_mltd,
  output logic       en_multr,
  output logic       en_ac,
  output logic       en_count,
  output logic [1:0] alu_op,
  output logic       selQ,
  output logic       selA,
  output logic       selQ_1,
  output logic       en_out,
  output logic       clear,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // The product bus is sized by the datapath; a mismatch here means the
  // datapath and this sequencer disagree on the iteration count.
  if (WIDTH_P != 2 * WIDTH_M) begin : g_width_check
    $error("booth_seq_controller: WIDTH_P must equal 2*WIDTH_M");
  end

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    err_d     = err_q;
    src_ready = 1'b0;
    dst_valid = 1'b0;
    start     = 1'b0;
    en_mltd   = 1'b0;
    en_multr  = 1'b0;
    en_ac     = 1'b0;
    en_count  = 1'b0;
    alu_op    = ALU_PASS;
    selQ      = 1'b0;
    selA      = 1'b0;
    selQ_1    = 1'b0;
    en_out    = 1'b1;
    clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        src_ready = 1'b1;
        if (src_valid) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
          timer_d = '0;
        end
      end

      ST_LOAD: begin
        start    = 1'b1;
        en_mltd  = 1'b1;
        en_multr = 1'b1;
        en_ac    = 1'b1;
        state_d  = ST_CALC;
      end

      ST_CALC: begin
        selQ   = 1'b1;
        selA   = 1'b1;
        selQ_1 = 1'b1;
        if (count_done) begin
          state_d = ST_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Counter never reported completion: abandon the product and flag it.
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          en_multr = 1'b1;
          en_ac    = 1'b1;
          en_count = 1'b1;
          alu_op   = booth_op_f(Q0, Q_1);
          if (timer_q != TW'(TIMEOUT)) begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        dst_valid = 1'b1;
        en_out    = 1'b0;
        // Clear fires in the handshake cycle so the datapath is zeroed by the
        // time IDLE can accept the next operand pair.
        if (dst_ready) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule
